// File: rtl/alu_pkg.sv
// Shared opcodes and saturation helpers for the pipelined fixed-point ALU.
// Helpers work on a wide signed value; callers truncate to their data width.
package alu_pkg;

    localparam int OP_ADD    = 0;
    localparam int OP_SUB    = 1;
    localparam int OP_MUL    = 2;
    localparam int OP_NAND   = 3;
    localparam int OP_XNOR   = 4;
    localparam int OP_ROTR   = 5;
    localparam int OP_MIN    = 6;
    localparam int OP_MAX    = 7;
    localparam int OP_MAC    = 8;
    localparam int OP_CLRACC = 9;

    localparam int CALC_W = 64;

    function automatic logic signed [CALC_W-1:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [CALC_W-1:0] saturate(input logic signed [CALC_W-1:0] v,
                                                         input int unsigned w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

    function automatic logic clips(input logic signed [CALC_W-1:0] v, input int unsigned w);
        return (v > sat_max(w)) || (v < sat_min(w));
    endfunction

endpackage

// File: rtl/alu_fx_mul.sv
// Signed fixed-point multiplier: raw product for stage 1, then round/shift/saturate
// of the registered product in stage 2.
module alu_fx_mul
    import alu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAC_W    = 5,
    parameter int MUL_ROUND = 1
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] prod,
    input  logic signed [2*DATA_W-1:0] prod_q,
    output logic signed [DATA_W-1:0]   res,
    output logic                       ovf
);

    localparam int HALF = (MUL_ROUND != 0) ? (1 << (FRAC_W - 1)) : 0;

    logic signed [2*DATA_W:0] rnd;
    logic signed [2*DATA_W:0] shifted;

    assign prod = a * b;

    // One guard bit so the rounding constant cannot wrap the product.
    assign rnd     = {prod_q[2*DATA_W-1], prod_q} + (2*DATA_W+1)'(HALF);
    assign shifted = rnd >>> FRAC_W;

    assign res = DATA_W'(saturate(64'(shifted), DATA_W));
    assign ovf = clips(64'(shifted), DATA_W);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined signed fixed-point ALU with valid/ready handshake,
// saturation reporting and a saturating multiply-accumulate.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int INT_W     = 3,
    parameter int FRAC_W    = 5,
    parameter int DATA_W    = INT_W + FRAC_W,
    parameter int INST_W    = 4,
    parameter int MUL_ROUND = 1,
    parameter int SH_W      = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat,
    output logic              o_err
);

    logic                       adv1, adv2;
    logic                       s1_valid;
    logic signed [DATA_W-1:0]   s1_a, s1_b;
    logic [INST_W-1:0]          s1_inst;
    logic signed [2*DATA_W-1:0] s1_prod, prod;
    logic signed [DATA_W-1:0]   mul_res;
    logic                       mul_ovf;
    logic signed [DATA_W-1:0]   acc, acc_nxt;
    logic                       acc_wr;
    logic signed [DATA_W:0]     sum, diff, acc_sum;
    logic [DATA_W-1:0]          res;
    logic                       sat, err;
    int                         rot_amt;

    assign adv2    = i_ready || !o_valid;
    assign adv1    = adv2 || !s1_valid;
    assign o_ready = adv1;

    alu_fx_mul #(
        .DATA_W    (DATA_W),
        .FRAC_W    (FRAC_W),
        .MUL_ROUND (MUL_ROUND)
    ) u_mul (
        .a      (i_data_a),
        .b      (i_data_b),
        .prod   (prod),
        .prod_q (s1_prod),
        .res    (mul_res),
        .ovf    (mul_ovf)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_inst  <= '0;
            s1_prod  <= '0;
        end else if (adv1) begin
            s1_valid <= i_valid;
            s1_a     <= i_data_a;
            s1_b     <= i_data_b;
            s1_inst  <= i_inst;
            s1_prod  <= prod;
        end
    end

    assign sum     = {s1_a[DATA_W-1], s1_a} + {s1_b[DATA_W-1], s1_b};
    assign diff    = {s1_a[DATA_W-1], s1_a} - {s1_b[DATA_W-1], s1_b};
    assign acc_sum = {acc[DATA_W-1], acc} + {mul_res[DATA_W-1], mul_res};
    assign rot_amt = int'(s1_b[SH_W-1:0]) % DATA_W;

    always_comb begin
        res     = '0;
        sat     = 1'b0;
        err     = 1'b0;
        acc_wr  = 1'b0;
        acc_nxt = acc;
        case (int'(s1_inst))
            OP_ADD: begin
                res = DATA_W'(saturate(64'(sum), DATA_W));
                sat = clips(64'(sum), DATA_W);
            end
            OP_SUB: begin
                res = DATA_W'(saturate(64'(diff), DATA_W));
                sat = clips(64'(diff), DATA_W);
            end
            OP_MUL: begin
                res = mul_res;
                sat = mul_ovf;
            end
            OP_NAND: res = ~(s1_a & s1_b);
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_ROTR: res = DATA_W'({s1_a, s1_a} >> rot_amt);
            OP_MIN:  res = (s1_a < s1_b) ? s1_a : s1_b;
            OP_MAX:  res = (s1_a > s1_b) ? s1_a : s1_b;
            OP_MAC: begin
                res     = DATA_W'(saturate(64'(acc_sum), DATA_W));
                sat     = mul_ovf || clips(64'(acc_sum), DATA_W);
                acc_nxt = res;
                acc_wr  = 1'b1;
            end
            OP_CLRACC: begin
                acc_nxt = '0;
                acc_wr  = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

    // The accumulator moves only with a stage-2 load, so a stalled MAC cannot apply twice.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
            o_err   <= 1'b0;
            acc     <= '0;
        end else if (adv2) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data <= res;
                o_sat  <= sat;
                o_err  <= err;
                if (acc_wr) acc <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed vectors through an in-order result queue,
// plus latency, backpressure, accumulator-stall and reset scenarios.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       rdy;
    logic [7:0] data_a, data_b;
    logic [3:0] inst;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_sat, res_err;
    logic       t_ready, t_valid;
    logic [7:0] t_data;
    logic       t_sat, t_err;

    typedef struct {
        int d;
        int s;
        int e;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         total = 0;
    int         bad = 0;
    int         accepted = 0;
    int         seen = 0;
    int         a0;
    logic       stalled = 1'b0;
    logic [7:0] held_d;
    logic       held_s, held_e;

    always #5 clk = ~clk;

    alu_pipe #(
        .INT_W     (3),
        .FRAC_W    (5),
        .INST_W    (4),
        .MUL_ROUND (1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .o_ready  (rdy),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_inst   (inst),
        .o_valid  (res_valid),
        .i_ready  (res_ready),
        .o_data   (res_data),
        .o_sat    (res_sat),
        .o_err    (res_err)
    );

    alu_pipe #(
        .INT_W     (3),
        .FRAC_W    (5),
        .INST_W    (4),
        .MUL_ROUND (0)
    ) dut_trunc (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .o_ready  (t_ready),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_inst   (inst),
        .o_valid  (t_valid),
        .i_ready  (res_ready),
        .o_data   (t_data),
        .o_sat    (t_sat),
        .o_err    (t_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int op, input int a, input int b,
                        input int ed, input int es, input int ee);
        inst   = 4'(op);
        data_a = 8'(a);
        data_b = 8'(b);
        valid  = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (rdy) begin
                exp_q.push_back('{ed, es, ee});
                accepted++;
                @(posedge clk);
                #1;
                valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Result monitor: in-order scoreboard plus hold-stable check while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && res_valid) begin
                if (stalled) begin
                    check("hold_data", 32'(res_data), 32'(held_d));
                    check("hold_sat", 32'(res_sat), 32'(held_s));
                    check("hold_err", 32'(res_err), 32'(held_e));
                end
                if (res_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("extra_result", 32'(res_data), 32'hFFFF);
                    end else begin
                        cur = exp_q.pop_front();
                        check($sformatf("data%0d", seen), 32'(res_data), cur.d);
                        check($sformatf("sat%0d", seen), 32'(res_sat), cur.s);
                        check($sformatf("err%0d", seen), 32'(res_err), cur.e);
                        seen++;
                    end
                end else begin
                    stalled = 1'b1;
                    held_d  = res_data;
                    held_s  = res_sat;
                    held_e  = res_err;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        valid     = 1'b0;
        inst      = '0;
        data_a    = '0;
        data_b    = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_sat", 32'(res_sat), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(rdy), 32'd1);

        // Latency: result visible after the edge following the accept.
        send(OP_ADD, 'h60, 'h40, 'h7F, 1, 0);
        check("lat_empty", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(res_valid), 32'd1);
        check("lat_data", 32'(res_data), 32'h7F);
        drain();

        send(OP_SUB, 'h80, 'h20, 'h80, 1, 0);
        send(OP_ADD, 'h10, 'h08, 'h18, 0, 0);
        send(OP_ADD, 'h7F, 'h01, 'h7F, 1, 0);
        send(OP_ADD, 'h80, 'hFF, 'h80, 1, 0);
        send(OP_SUB, 'h7F, 'h80, 'h7F, 1, 0);
        send(OP_MUL, 'h30, 'h30, 'h48, 0, 0);
        send(OP_MUL, 'h01, 'h10, 'h01, 0, 0);
        @(posedge clk);
        #1;
        check("trunc_valid", 32'(t_valid), 32'd1);
        check("trunc_data", 32'(t_data), 32'h00);
        check("trunc_sat", 32'(t_sat), 32'd0);
        check("trunc_err", 32'(t_err), 32'd0);
        check("trunc_ready", 32'(t_ready), 32'd1);
        send(OP_MUL, 'h60, 'h60, 'h7F, 1, 0);
        send(OP_NAND, 'hF0, 'h3C, 'hCF, 0, 0);
        send(OP_XNOR, 'hF0, 'h3C, 'h33, 0, 0);
        send(OP_ROTR, 'h81, 'h01, 'hC0, 0, 0);
        send(OP_ROTR, 'h81, 'h0B, 'h30, 0, 0);
        send(OP_ROTR, 'h5A, 'h08, 'h5A, 0, 0);
        send(OP_MIN, 'h80, 'h7F, 'h80, 0, 0);
        send(OP_MAX, 'h80, 'h7F, 'h7F, 0, 0);
        send(12, 'h11, 'h22, 'h00, 0, 1);
        send(15, 'h7F, 'h7F, 'h00, 0, 1);
        send(OP_CLRACC, 'h55, 'h55, 'h00, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h20, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h40, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h60, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h7F, 1, 0);
        send(OP_MAC, 'hE0, 'h20, 'h5F, 0, 0);
        drain();

        // Six ADDs against a five-cycle output stall.
        res_ready = 1'b0;
        a0 = accepted;
        fork
            begin
                for (int i = 0; i < 6; i++) send(OP_ADD, i * 3, 'h10, i * 3 + 'h10, 0, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_accepted", accepted - a0, 32'd2);
                check("bp_ready_low", 32'(rdy), 32'd0);
                res_ready = 1'b1;
            end
        join
        drain();

        // A MAC parked in stage 2 must update the accumulator once.
        send(OP_CLRACC, 0, 0, 'h00, 0, 0);
        drain();
        res_ready = 1'b0;
        send(OP_MAC, 'h20, 'h20, 'h20, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h40, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(OP_MAC, 'h20, 'h20, 'h60, 0, 0);
        drain();

        // Reset with both stages full and acc = 0x40.
        send(OP_CLRACC, 0, 0, 'h00, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h20, 0, 0);
        send(OP_MAC, 'h20, 'h20, 'h40, 0, 0);
        drain();
        res_ready = 1'b0;
        send(OP_ADD, 'h01, 'h01, 'h02, 0, 0);
        send(OP_ADD, 'h02, 'h02, 'h04, 0, 0);
        @(negedge clk);
        check("full_ready_low", 32'(rdy), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_data", 32'(res_data), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        check("arst_ready", 32'(rdy), 32'd1);
        send(OP_MAC, 'h20, 'h20, 'h20, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
